// File: rtl/ahb_mtimer.sv
// ahb_mtimer: RISC-V machine timer (mtime/mtimecmp) behind a zero-wait-state AHB-Lite slave.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   hsel_i          - slave select
//   haddr_i         - byte address within the timer window
//   htrans_i        - transfer type; only NONSEQ/SEQ start a transfer
//   hwrite_i        - 1 = write
//   hsize_i         - 0 byte, 1 half, 2+ word
//   hwdata_i        - write data (data phase)
//   hready_i        - bus-wide HREADY
//   hrdata_o        - read data (data phase, combinational from latched address)
//   hreadyout_o     - always 1
//   hresp_o         - always 0 (OKAY)
//   timer_irq_o     - registered level interrupt: EN & (mtime >= mtimecmp)
//
// Register map (byte offsets): 0x00 CTRL (bit0 EN), 0x04 PRESCALE, 0x08 MTIME_LO,
// 0x0C MTIME_HI, 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI. Other offsets read 0, ignore writes.

module ahb_mtimer #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [31:0]       hwdata_i,
    input  logic              hready_i,
    output logic [31:0]       hrdata_o,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic              timer_irq_o
);

    localparam int unsigned IdxW = ADDR_W - 2;

    localparam logic [IdxW-1:0] IdxCtrl   = IdxW'(0);
    localparam logic [IdxW-1:0] IdxPresc  = IdxW'(1);
    localparam logic [IdxW-1:0] IdxTimeLo = IdxW'(2);
    localparam logic [IdxW-1:0] IdxTimeHi = IdxW'(3);
    localparam logic [IdxW-1:0] IdxCmpLo  = IdxW'(4);
    localparam logic [IdxW-1:0] IdxCmpHi  = IdxW'(5);

    // Latched address phase
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    // Timer state
    logic                  en_q, en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  irq_q, irq_d;

    logic [IdxW-1:0] word_idx;
    logic [3:0]      byte_en;
    logic            wr_en;
    logic            tick;
    logic [63:0]     mtime_inc;
    logic [31:0]     rd_word;
    logic [31:0]     wr_base;
    logic [31:0]     wr_word;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign word_idx = addr_q[ADDR_W-1:2];
    assign wr_en    = valid_q & write_q;

    // Byte lanes of the latched transfer; sizes above word behave as word.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'd0:    byte_en[addr_q[1:0]] = 1'b1;
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Current register contents as seen by a read
    always_comb begin
        rd_word = 32'h0;
        case (word_idx)
            IdxCtrl:   rd_word = {31'h0, en_q};
            IdxPresc:  rd_word = 32'(prescale_q);
            IdxTimeLo: rd_word = mtime_q[31:0];
            IdxTimeHi: rd_word = mtime_q[63:32];
            IdxCmpLo:  rd_word = mtimecmp_q[31:0];
            IdxCmpHi:  rd_word = mtimecmp_q[63:32];
            default:   rd_word = 32'h0;
        endcase
    end

    assign tick      = en_q && (pcnt_q == prescale_q);
    assign mtime_inc = mtime_q + 64'(tick);

    // Partial writes to mtime merge onto the post-tick value so the unwritten bytes
    // (and the other half, via carry) still advance.
    always_comb begin
        wr_base = rd_word;
        if (word_idx == IdxTimeLo) begin
            wr_base = mtime_inc[31:0];
        end else if (word_idx == IdxTimeHi) begin
            wr_base = mtime_inc[63:32];
        end
    end

    assign wr_word = merge_bytes(wr_base, hwdata_i, byte_en);

    always_comb begin
        en_d       = en_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        if (wr_en) begin
            case (word_idx)
                IdxCtrl:   en_d = wr_word[0];
                IdxPresc: begin
                    prescale_d = wr_word[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                IdxTimeLo: mtime_d[31:0]     = wr_word;
                IdxTimeHi: mtime_d[63:32]    = wr_word;
                IdxCmpLo:  mtimecmp_d[31:0]  = wr_word;
                IdxCmpHi:  mtimecmp_d[63:32] = wr_word;
                default: ;
            endcase
        end

        // Compare uses pre-update values, giving one cycle of latency to the pin.
        irq_d = en_q && (mtime_q >= mtimecmp_q);

        valid_d = hsel_i & htrans_i[1] & hready_i;
        addr_d  = haddr_i;
        write_d = hwrite_i;
        size_d  = hsize_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            en_q       <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    assign hrdata_o    = (valid_q && !write_q) ? rd_word : 32'h0;
    assign hreadyout_o = 1'b1;
    assign hresp_o     = 1'b0;
    assign timer_irq_o = irq_q;

endmodule
